// File: rtl/ureg_pkg.sv
// ---------------------------------------------------------------------------
// ureg_pkg
// Shared definitions for the universal shift register sequencer.
//   op_e    : command op codes. Each value equals the register CTRL code that
//             the command drives (00 hold, 01 shift MSB<LSB, 10 load,
//             11 shift MSB>LSB).
//   fill_e  : serial-in source selection for shift commands.
//   state_e : sequencer FSM states.
//   fill_bit / is_shift : small helpers used by the sequencer datapath.
// ---------------------------------------------------------------------------
package ureg_pkg;

    localparam int UREG_WIDTH      = 8;
    localparam int UREG_CNT_W      = 4;
    localparam int UREG_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        OP_WAIT = 2'b00,
        OP_SHL  = 2'b01,
        OP_LOAD = 2'b10,
        OP_SHR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'b00,
        FILL_ONE  = 2'b01,
        FILL_EXT  = 2'b10,
        FILL_ROT  = 2'b11
    } fill_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Serial-in bit for a shift given its fill source.
    function automatic logic fill_bit(input fill_e fill, input logic ext, input logic rot);
        logic bit_val;
        case (fill)
            FILL_ZERO: bit_val = 1'b0;
            FILL_ONE:  bit_val = 1'b1;
            FILL_EXT:  bit_val = ext;
            default:   bit_val = rot;
        endcase
        return bit_val;
    endfunction

    function automatic logic is_shift(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/ureg_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ureg_cmd_fifo
// Small synchronous command queue. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally. A push while full is dropped even if a pop happens
// on the same edge; the head word is presented combinationally.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, empties the queue
//   push       in   write push_data at this edge (ignored when full)
//   push_data  in   DATA_W command word
//   pop        in   drop the head entry at this edge (ignored when empty)
//   head       out  oldest entry
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   count      out  number of entries held
// ---------------------------------------------------------------------------
module ureg_cmd_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the empty flag guarantees stale
    // words are never consumed, and leaving it unreset keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ureg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ureg_seq_ctrl
// Command sequencer for an 8-bit universal shift register. Commands (WAIT,
// SHL, LOAD, SHR) arrive over a valid/ready handshake into a small queue and
// are executed one at a time: IDLE pops a command, EXEC drives the register
// for the requested number of cycles, DONE pulses done for one cycle.
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   synchronous reset, ACTIVE HIGH (name fixed by the harness)
//   ena         in   global enable; low freezes all state and idles outputs
//   cmd_valid   in   command present
//   cmd_ready   out  queue can accept (!full & ena & !rst_n)
//   cmd_op      in   00 WAIT, 01 SHL, 10 LOAD, 11 SHR
//   cmd_cnt     in   execute cycles for WAIT/SHL/SHR (ignored for LOAD)
//   cmd_fill    in   serial-in source: 00 zero, 01 one, 10 ext_sin, 11 rotate
//   cmd_data    in   parallel value for LOAD
//   ext_sin     in   external serial bit
//   reg_q       in   current register contents
//   reg_ctrl    out  register mode select
//   reg_sin     out  register serial input
//   reg_d       out  register parallel input
//   reg_en      out  register clock enable
//   sout        out  bit leaving the register this cycle
//   sout_valid  out  sout meaningful (SHL/SHR execute cycles)
//   busy        out  command in flight or queued
//   done        out  one-cycle pulse at the end of each command
// ---------------------------------------------------------------------------
module ureg_seq_ctrl
    import ureg_pkg::*;
#(
    parameter int WIDTH      = UREG_WIDTH,
    parameter int CNT_W      = UREG_CNT_W,
    parameter int FIFO_DEPTH = UREG_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic [1:0]        cmd_fill,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic              ext_sin,
    input  logic [WIDTH-1:0]  reg_q,
    output logic [1:0]        reg_ctrl,
    output logic              reg_sin,
    output logic [WIDTH-1:0]  reg_d,
    output logic              reg_en,
    output logic              sout,
    output logic              sout_valid,
    output logic              busy,
    output logic              done
);

    // Queue word layout: {op, cnt, fill, data}
    localparam int CMD_W = 2 + CNT_W + 2 + WIDTH;
    localparam int QC_W  = $clog2(FIFO_DEPTH) + 1;

    logic [CMD_W-1:0] push_word;
    logic [CMD_W-1:0] head_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic [QC_W-1:0]  fifo_count;
    logic [QC_W-1:0]  count_after;
    logic             push;
    logic             pop;

    op_e              head_op;
    fill_e            head_fill;
    logic [CNT_W-1:0] head_cnt;
    logic [WIDTH-1:0] head_data;

    state_e           state;
    logic [CNT_W-1:0] counter;
    op_e              ex_op;
    fill_e            ex_fill;

    op_e              ctrl_q;
    logic             sin_q;
    logic [WIDTH-1:0] d_q;
    logic             en_q;
    logic             sv_q;
    logic             busy_q;
    logic             done_q;

    logic             rot_entry;
    logic             rot_next;
    logic             reg_q_unused;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    assign cmd_ready = !fifo_full && ena && !rst_n;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = ena && !rst_n && (state == ST_IDLE) && !fifo_empty;
    assign push_word = {cmd_op, cmd_cnt, cmd_fill, cmd_data};

    ureg_cmd_fifo #(
        .DATA_W (CMD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_op   = op_e'(head_word[CMD_W-1 -: 2]);
    assign head_cnt  = head_word[WIDTH+2 +: CNT_W];
    assign head_fill = fill_e'(head_word[WIDTH +: 2]);
    assign head_data = head_word[WIDTH-1:0];

    // Queue occupancy after this edge, used to register busy.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        count_after = fifo_count;
        if (push && !pop)      count_after = fifo_count + 1'b1;
        else if (pop && !push) count_after = fifo_count - 1'b1;
    end

    // reg_sin is registered, so the rotate bit must be the one that sits at
    // the exit end of the register during the coming cycle. On entry from
    // IDLE the register is idle, so that is the current exit bit; while
    // shifting it is the bit one position in from the exit end.
    always_comb begin
        rot_entry = (head_op == OP_SHR) ? reg_q[0] : reg_q[WIDTH-1];
        rot_next  = (ex_op   == OP_SHR) ? reg_q[1] : reg_q[WIDTH-2];
    end

    // Explicit sink for reg_q bits the sequencer never inspects.
    assign reg_q_unused = &{1'b0, reg_q};

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs. Output registers hold the
    // values for the state being entered; they default to idle and the
    // state arms override them. FILL_EXT samples ext_sin one edge ahead.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= ST_IDLE;
            counter <= '0;
            ex_op   <= OP_WAIT;
            ex_fill <= FILL_ZERO;
            ctrl_q  <= OP_WAIT;
            sin_q   <= 1'b0;
            d_q     <= '0;
            en_q    <= 1'b0;
            sv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            ctrl_q <= OP_WAIT;
            sin_q  <= 1'b0;
            d_q    <= '0;
            en_q   <= 1'b0;
            sv_q   <= 1'b0;
            done_q <= 1'b0;
            busy_q <= (count_after != '0);

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        ex_op   <= head_op;
                        ex_fill <= head_fill;
                        busy_q  <= 1'b1;
                        if (head_op == OP_LOAD) begin
                            counter <= CNT_W'(1);
                            state   <= ST_EXEC;
                            en_q    <= 1'b1;
                            ctrl_q  <= OP_LOAD;
                            d_q     <= head_data;
                        end else if (head_cnt == '0) begin
                            // Zero-length command: skip EXEC, still report done.
                            counter <= '0;
                            state   <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            counter <= head_cnt;
                            state   <= ST_EXEC;
                            en_q    <= 1'b1;
                            ctrl_q  <= head_op;
                            sv_q    <= is_shift(head_op);
                            sin_q   <= is_shift(head_op) &&
                                       fill_bit(head_fill, ext_sin, rot_entry);
                        end
                    end
                end

                ST_EXEC: begin
                    counter <= counter - CNT_W'(1);
                    busy_q  <= 1'b1;
                    if (counter == CNT_W'(1)) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        en_q   <= 1'b1;
                        ctrl_q <= ex_op;
                        sv_q   <= is_shift(ex_op);
                        sin_q  <= is_shift(ex_op) &&
                                  fill_bit(ex_fill, ext_sin, rot_next);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. ena gates the register-facing flops directly so the
    // register never advances during a cycle in which the FSM is frozen,
    // and a suppressed done pulse reappears once ena returns.
    // ------------------------------------------------------------------
    assign reg_en     = en_q && ena;
    assign reg_ctrl   = ena ? ctrl_q : OP_WAIT;
    assign reg_d      = ena ? d_q : '0;
    assign reg_sin    = sin_q && ena;
    assign sout_valid = sv_q && ena;
    assign done       = done_q && ena;
    assign busy       = busy_q;
    assign sout       = sout_valid && ((ex_op == OP_SHR) ? reg_q[0] : reg_q[WIDTH-1]);

endmodule

// File: tb/tb_ureg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ureg_seq_ctrl
// Directed bench for ureg_seq_ctrl driving a behavioural 8-bit universal
// shift register. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ureg_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [1:0]       cmd_fill;
    logic [WIDTH-1:0] cmd_data;
    logic             ext_sin;
    logic [WIDTH-1:0] reg_q;
    logic [1:0]       reg_ctrl;
    logic             reg_sin;
    logic [WIDTH-1:0] reg_d;
    logic             reg_en;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          en_cycles;
    int          sv_cycles;
    int          done_cnt;
    int          sn;
    logic [31:0] sbits;

    always #5 clk = ~clk;

    ureg_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_cnt    (cmd_cnt),
        .cmd_fill   (cmd_fill),
        .cmd_data   (cmd_data),
        .ext_sin    (ext_sin),
        .reg_q      (reg_q),
        .reg_ctrl   (reg_ctrl),
        .reg_sin    (reg_sin),
        .reg_d      (reg_d),
        .reg_en     (reg_en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    // Universal shift register: 00 hold, 01 shift toward MSB, 10 load,
    // 11 shift toward LSB. Never reset by the sequencer.
    always_ff @(posedge clk) begin
        if (reg_en) begin
            case (reg_ctrl)
                2'b01:   reg_q <= {reg_q[WIDTH-2:0], reg_sin};
                2'b10:   reg_q <= reg_d;
                2'b11:   reg_q <= {reg_sin, reg_q[WIDTH-1:1]};
                default: reg_q <= reg_q;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        en_cycles = 0;
        sv_cycles = 0;
        done_cnt  = 0;
        sn        = 0;
        sbits     = '0;
    endtask

    // One clock: rising edge, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (reg_en) en_cycles++;
        if (sout_valid) begin
            if (sn < 32) sbits[sn] = sout;
            sn++;
            sv_cycles++;
        end
        if (done) done_cnt++;
    endtask

    task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                        input logic [1:0] fill, input logic [WIDTH-1:0] data);
        logic accepted;
        accepted  = 1'b0;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_fill  = fill;
        cmd_data  = data;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) begin
                accepted = 1'b1;
                step();
                break;
            end
            step();
        end
        cmd_valid = 1'b0;
        if (!accepted) check("send_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic run_until_idle(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (!busy) break;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_until_en(input int n, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (en_cycles >= n) break;
            step();
        end
        check("en_reach", 32'(en_cycles >= n), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        ena       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;
        cmd_fill  = 2'b00;
        cmd_data  = '0;
        ext_sin   = 1'b0;
        clear_stats();
        @(negedge clk);
        step();
        step();

        // Reset state
        check("rst_reg_en",     32'(reg_en),     32'd0);
        check("rst_reg_ctrl",   32'(reg_ctrl),   32'd0);
        check("rst_reg_d",      32'(reg_d),      32'd0);
        check("rst_reg_sin",    32'(reg_sin),    32'd0);
        check("rst_sout",       32'(sout),       32'd0);
        check("rst_sout_valid", 32'(sout_valid), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
        rst_n = 1'b0;
        #1;
        check("post_rst_ready", 32'(cmd_ready),  32'd1);

        // LOAD 0xA5: one EXEC cycle, done one cycle later, busy falls after.
        clear_stats();
        send(2'b10, 4'd0, 2'b00, 8'hA5);
        check("load_busy_q",  32'(busy),     32'd1);
        check("load_en_wait", 32'(reg_en),   32'd0);
        step();
        check("load_en",      32'(reg_en),   32'd1);
        check("load_ctrl",    32'(reg_ctrl), 32'd2);
        check("load_d",       32'(reg_d),    32'hA5);
        check("load_done_lo", 32'(done),     32'd0);
        step();
        check("load_q",       32'(reg_q),    32'hA5);
        check("load_done",    32'(done),     32'd1);
        check("load_en_off",  32'(reg_en),   32'd0);
        check("load_busy_d",  32'(busy),     32'd1);
        step();
        check("load_done_end", 32'(done),    32'd0);
        check("load_busy_end", 32'(busy),    32'd0);

        // LOAD 0x81, SHL 8 rotate: stream 1,0,0,0,0,0,0,1 and 0x81 back.
        clear_stats();
        send(2'b10, 4'd0, 2'b00, 8'h81);
        send(2'b01, 4'd8, 2'b11, 8'h00);
        run_until_idle("rotl", 40);
        check("rotl_q",      32'(reg_q),      32'h81);
        check("rotl_stream", sbits,           32'h81);
        check("rotl_sv",     32'(sv_cycles),  32'd8);
        check("rotl_en",     32'(en_cycles),  32'd9);
        check("rotl_done",   32'(done_cnt),   32'd2);

        // LOAD 0xF0, SHR 3 fill one -> 0xFE, sout 0,0,0.
        clear_stats();
        send(2'b10, 4'd0, 2'b00, 8'hF0);
        send(2'b11, 4'd3, 2'b01, 8'h00);
        run_until_idle("shr1", 30);
        check("shr1_q",      32'(reg_q),     32'hFE);
        check("shr1_stream", sbits,          32'h0);
        check("shr1_sv",     32'(sv_cycles), 32'd3);

        // LOAD 0x00, SHL 2 from ext_sin=1 -> 0x03.
        clear_stats();
        ext_sin = 1'b1;
        send(2'b10, 4'd0, 2'b00, 8'h00);
        send(2'b01, 4'd2, 2'b10, 8'h00);
        run_until_idle("ext", 30);
        ext_sin = 1'b0;
        check("ext_q", 32'(reg_q), 32'h03);

        // SHL cnt=0: no register cycle, done one edge after the pop.
        clear_stats();
        send(2'b01, 4'd0, 2'b11, 8'h00);
        step();
        check("cnt0_done",   32'(done),      32'd1);
        check("cnt0_en",     32'(reg_en),    32'd0);
        step();
        check("cnt0_done_lo", 32'(done),     32'd0);
        check("cnt0_busy",   32'(busy),      32'd0);
        check("cnt0_q",      32'(reg_q),     32'h03);
        check("cnt0_en_tot", 32'(en_cycles), 32'd0);

        // WAIT 4: register held, four enabled hold cycles, then done.
        // ena drops during the done cycle: done hidden, then re-issued.
        clear_stats();
        send(2'b00, 4'd4, 2'b00, 8'h00);
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            step();
        end
        check("wait_done",   32'(done),      32'd1);
        check("wait_en",     32'(en_cycles), 32'd4);
        check("wait_sv",     32'(sv_cycles), 32'd0);
        check("wait_q",      32'(reg_q),     32'h03);
        ena = 1'b0;
        #1;
        check("frz_done",    32'(done),      32'd0);
        check("frz_ready",   32'(cmd_ready), 32'd0);
        step();
        step();
        check("frz_done2",   32'(done),      32'd0);
        ena = 1'b1;
        #1;
        check("redo_done",   32'(done),      32'd1);
        step();
        check("redo_done_lo", 32'(done),     32'd0);
        check("redo_busy",   32'(busy),      32'd0);

        // Queue fills while a WAIT runs; third push waits for a pop.
        clear_stats();
        send(2'b00, 4'd6, 2'b00, 8'h00);
        send(2'b10, 4'd0, 2'b00, 8'h3C);
        send(2'b01, 4'd2, 2'b01, 8'h00);
        check("full_ready",  32'(cmd_ready), 32'd0);
        send(2'b11, 4'd1, 2'b00, 8'h00);
        run_until_idle("b2b", 60);
        check("b2b_q",       32'(reg_q),     32'h79);
        check("b2b_done",    32'(done_cnt),  32'd4);

        // Reset during the third SHL cycle: queued LOAD discarded, no done,
        // register keeps the three completed shifts.
        clear_stats();
        send(2'b10, 4'd0, 2'b00, 8'h0F);
        run_until_idle("pre_rst", 20);
        clear_stats();
        send(2'b01, 4'd8, 2'b00, 8'h00);
        send(2'b10, 4'd0, 2'b00, 8'hFF);
        run_until_en(3, 20);
        rst_n = 1'b1;
        step();
        check("mrst_en",     32'(reg_en),    32'd0);
        check("mrst_busy",   32'(busy),      32'd0);
        check("mrst_done",   32'(done),      32'd0);
        check("mrst_ready",  32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        clear_stats();
        for (int i = 0; i < 4; i++) step();
        check("mrst_q",      32'(reg_q),     32'h78);
        check("mrst_nodone", 32'(done_cnt),  32'd0);
        check("mrst_noen",   32'(en_cycles), 32'd0);

        // LOAD 0xB4, SHR 4 zero with ena low for three cycles mid-shift.
        clear_stats();
        send(2'b10, 4'd0, 2'b00, 8'hB4);
        run_until_idle("pre_frz", 20);
        clear_stats();
        send(2'b11, 4'd4, 2'b00, 8'h00);
        run_until_en(2, 20);
        ena = 1'b0;
        #1;
        check("sfrz_en",     32'(reg_en),     32'd0);
        check("sfrz_sv",     32'(sout_valid), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("sfrz_q",      32'(reg_q),      32'h5A);
        check("sfrz_busy",   32'(busy),       32'd1);
        check("sfrz_en_tot", 32'(en_cycles),  32'd2);
        ena = 1'b1;
        run_until_idle("sfrz", 30);
        check("sfrz_q_end",  32'(reg_q),      32'h0B);
        check("sfrz_en_end", 32'(en_cycles),  32'd4);
        check("sfrz_stream", sbits,           32'h4);
        check("sfrz_done",   32'(done_cnt),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
